// File: rtl/freq_divider_prog.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | freq_divider_prog: runtime-programmable integer clock divider that drives   |
// | a near-50% clk_out and a period-start tick, reloadable via load/ack.        |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module freq_divider_prog #(
  parameter int CNT_W       = 16,
  parameter int DEFAULT_DIV = 1000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [CNT_W-1:0] div_val,
  input  logic             div_load,
  output logic             div_pend,
  output logic             div_ack,
  output logic [CNT_W-1:0] div_cur,
  output logic             clk_out,
  output logic             tick
);

  localparam logic [CNT_W-1:0] C_DEFAULT_DIV = CNT_W'(DEFAULT_DIV);
  localparam logic [CNT_W-1:0] C_MIN_DIV     = CNT_W'(2);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] div_cur_q, div_cur_d;
  logic [CNT_W-1:0] pend_val_q, pend_val_d;
  logic             div_pend_q, div_pend_d;
  logic             div_ack_q, div_ack_d;
  logic             clk_out_q, clk_out_d;
  logic             tick_q, tick_d;

  logic [CNT_W-1:0] w_clamped;
  logic [CNT_W-1:0] w_high;
  logic [CNT_W-1:0] w_eff_val;
  logic             w_last;
  logic             w_boundary;
  logic             w_eff_valid;

  always_comb begin
    w_clamped   = (div_val < C_MIN_DIV) ? C_MIN_DIV : div_val;
    w_high      = div_cur_q - (div_cur_q >> 1);
    w_last      = (cnt_q == (div_cur_q - CNT_W'(1)));
    // An idle divider has no period in flight, so every idle edge is a safe switch point.
    w_boundary  = !en || w_last;
    w_eff_valid = div_load || div_pend_q;
    w_eff_val   = div_load ? w_clamped : pend_val_q;

    cnt_d      = '0;
    clk_out_d  = 1'b0;
    tick_d     = 1'b0;
    div_cur_d  = div_cur_q;
    pend_val_d = pend_val_q;
    div_pend_d = div_pend_q;
    div_ack_d  = 1'b0;

    if (en) begin
      clk_out_d = (cnt_q < w_high);
      tick_d    = (cnt_q == '0);
      cnt_d     = w_last ? '0 : cnt_q + CNT_W'(1);
    end

    if (div_load) begin
      pend_val_d = w_clamped;
      div_pend_d = 1'b1;
    end

    if (w_boundary && w_eff_valid) begin
      div_cur_d  = w_eff_val;
      div_pend_d = 1'b0;
      div_ack_d  = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q      <= '0;
      div_cur_q  <= C_DEFAULT_DIV;
      pend_val_q <= C_DEFAULT_DIV;
      div_pend_q <= 1'b0;
      div_ack_q  <= 1'b0;
      clk_out_q  <= 1'b0;
      tick_q     <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      div_cur_q  <= div_cur_d;
      pend_val_q <= pend_val_d;
      div_pend_q <= div_pend_d;
      div_ack_q  <= div_ack_d;
      clk_out_q  <= clk_out_d;
      tick_q     <= tick_d;
    end
  end

  assign div_pend = div_pend_q;
  assign div_ack  = div_ack_q;
  assign div_cur  = div_cur_q;
  assign clk_out  = clk_out_q;
  assign tick     = tick_q;

endmodule
`default_nettype wire

// File: tb/tb_freq_divider_prog.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_freq_divider_prog: directed scenarios for freq_divider_prog.             |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module tb_freq_divider_prog;

  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             en;
  logic [CNT_W-1:0] div_val;
  logic             div_load;
  logic             div_pend;
  logic             div_ack;
  logic [CNT_W-1:0] div_cur;
  logic             clk_out;
  logic             tick;

  int n_tests = 0;
  int n_fail  = 0;

  freq_divider_prog #(.CNT_W(CNT_W), .DEFAULT_DIV(1000)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .div_val  (div_val),
    .div_load (div_load),
    .div_pend (div_pend),
    .div_ack  (div_ack),
    .div_cur  (div_cur),
    .clk_out  (clk_out),
    .tick     (tick)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", n_tests, n_fail);
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Runs whole periods of ratio n starting from cnt=0 and checks the waveform each edge.
  task automatic check_periods(input int n, input int periods, input string name);
    logic [3:0] got, exp;
    for (int j = 0; j < n * periods; j++) begin
      cyc();
      got = {clk_out, tick, div_ack, div_pend};
      exp = {logic'((j % n) < (n - n / 2)), logic'((j % n) == 0), 2'b00};
      n_tests++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL %s wave j=%0d: {clk_out,tick,ack,pend} got %b expected %b", name, j, got, exp);
      end
      n_tests++;
      if (div_cur !== CNT_W'(n)) begin
        n_fail++;
        $display("FAIL %s div_cur j=%0d: got %0d expected %0d", name, j, div_cur, n);
      end
    end
  endtask

  // Loads val on the cnt=0 edge of an n_cur period; the switch must land on that period's last edge.
  task automatic load_at_start(input int val, input int n_cur, input int exp_new, input string name);
    logic [1:0] ap;
    div_val  = CNT_W'(val);
    div_load = 1'b1;
    cyc();
    div_load = 1'b0;
    n_tests++;
    if ({div_ack, div_pend, clk_out, tick} !== 4'b0111) begin
      n_fail++;
      $display("FAIL %s load edge: {ack,pend,clk_out,tick} got %b expected 0111", name,
               {div_ack, div_pend, clk_out, tick});
    end
    for (int i = 1; i < n_cur; i++) begin
      cyc();
      n_tests++;
      if (clk_out !== logic'(i < (n_cur - n_cur / 2)) || tick !== 1'b0) begin
        n_fail++;
        $display("FAIL %s old wave i=%0d: clk_out=%b tick=%b expected %b 0", name, i, clk_out, tick,
                 logic'(i < (n_cur - n_cur / 2)));
      end
      ap = (i < n_cur - 1) ? 2'b01 : 2'b10;
      n_tests++;
      if ({div_ack, div_pend} !== ap) begin
        n_fail++;
        $display("FAIL %s handshake i=%0d: {ack,pend} got %b expected %b", name, i, {div_ack, div_pend}, ap);
      end
    end
    n_tests++;
    if (div_cur !== CNT_W'(exp_new)) begin
      n_fail++;
      $display("FAIL %s new div_cur: got %0d expected %0d", name, div_cur, exp_new);
    end
  endtask

  task automatic test_reset();
    rst      = 1'b1;
    en       = 1'b0;
    div_val  = '0;
    div_load = 1'b0;
    #3;
    n_tests++;
    if ({clk_out, tick, div_ack, div_pend} !== 4'b0000 || div_cur !== 16'd1000) begin
      n_fail++;
      $display("FAIL reset_async: {clk_out,tick,ack,pend}=%b div_cur=%0d expected 0000 1000",
               {clk_out, tick, div_ack, div_pend}, div_cur);
    end
    cyc();
    cyc();
    n_tests++;
    if ({clk_out, tick, div_ack, div_pend} !== 4'b0000 || div_cur !== 16'd1000) begin
      n_fail++;
      $display("FAIL reset_held: {clk_out,tick,ack,pend}=%b div_cur=%0d expected 0000 1000",
               {clk_out, tick, div_ack, div_pend}, div_cur);
    end
    rst = 1'b0;
  endtask

  task automatic test_default_run();
    en = 1'b1;
    check_periods(1000, 2, "default_run");
  endtask

  task automatic test_reload_mid_period();
    logic [1:0] ap;
    for (int i = 0; i < 1000; i++) begin
      div_load = (i == 300);
      div_val  = 16'd4;
      cyc();
      div_load = 1'b0;
      n_tests++;
      if (clk_out !== logic'(i < 500) || tick !== logic'(i == 0)) begin
        n_fail++;
        $display("FAIL reload_mid wave i=%0d: clk_out=%b tick=%b expected %b %b", i, clk_out, tick,
                 logic'(i < 500), logic'(i == 0));
      end
      ap = (i < 300) ? 2'b00 : (i < 999) ? 2'b01 : 2'b10;
      n_tests++;
      if ({div_ack, div_pend} !== ap) begin
        n_fail++;
        $display("FAIL reload_mid handshake i=%0d: {ack,pend} got %b expected %b", i, {div_ack, div_pend}, ap);
      end
    end
    n_tests++;
    if (div_cur !== 16'd4) begin
      n_fail++;
      $display("FAIL reload_mid div_cur: got %0d expected 4", div_cur);
    end
    check_periods(4, 3, "ratio4");
  endtask

  task automatic test_ratio_five();
    load_at_start(5, 4, 5, "load5");
    check_periods(5, 2, "ratio5");
  endtask

  task automatic test_clamp();
    load_at_start(0, 5, 2, "clamp0");
    check_periods(2, 3, "ratio2_from0");
    load_at_start(1, 2, 2, "clamp1");
    check_periods(2, 2, "ratio2_from1");
  endtask

  task automatic test_back_to_back();
    load_at_start(8, 2, 8, "load8");
    for (int i = 0; i < 8; i++) begin
      div_load = (i == 0) || (i == 3);
      div_val  = (i == 0) ? 16'd6 : 16'd10;
      cyc();
      div_load = 1'b0;
      n_tests++;
      if (div_ack !== logic'(i == 7) || div_cur !== ((i == 7) ? 16'd10 : 16'd8)) begin
        n_fail++;
        $display("FAIL overwrite i=%0d: ack=%b div_cur=%0d expected %b %0d", i, div_ack, div_cur,
                 logic'(i == 7), (i == 7) ? 10 : 8);
      end
    end
    check_periods(10, 1, "ratio10");
    for (int i = 0; i < 10; i++) begin
      div_load = (i == 9);
      div_val  = 16'd8;
      cyc();
      div_load = 1'b0;
      n_tests++;
      if ({div_ack, div_pend} !== ((i == 9) ? 2'b10 : 2'b00) || div_cur !== ((i == 9) ? 16'd8 : 16'd10)) begin
        n_fail++;
        $display("FAIL same_edge_load i=%0d: {ack,pend}=%b div_cur=%0d expected %b %0d", i,
                 {div_ack, div_pend}, div_cur, (i == 9) ? 2'b10 : 2'b00, (i == 9) ? 8 : 10);
      end
    end
    check_periods(8, 1, "ratio8_same_edge");
  endtask

  task automatic test_async_reset_idle();
    load_at_start(4, 8, 4, "load4");
    div_val  = 16'd7;
    div_load = 1'b1;
    cyc();
    div_load = 1'b0;
    n_tests++;
    if ({clk_out, div_pend} !== 2'b11) begin
      n_fail++;
      $display("FAIL pre_reset: {clk_out,pend} got %b expected 11", {clk_out, div_pend});
    end
    #1 rst = 1'b1;
    #1;
    n_tests++;
    if ({clk_out, tick, div_pend, div_ack} !== 4'b0000 || div_cur !== 16'd1000) begin
      n_fail++;
      $display("FAIL mid_reset: {clk_out,tick,pend,ack}=%b div_cur=%0d expected 0000 1000",
               {clk_out, tick, div_pend, div_ack}, div_cur);
    end
    en = 1'b0;
    cyc();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      n_tests++;
      if ({div_ack, div_pend} !== 2'b00 || div_cur !== 16'd1000) begin
        n_fail++;
        $display("FAIL post_reset i=%0d: {ack,pend}=%b div_cur=%0d expected 00 1000", i,
                 {div_ack, div_pend}, div_cur);
      end
    end
    en = 1'b1;
    for (int i = 0; i < 7; i++) cyc();
    en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      n_tests++;
      if ({clk_out, tick, div_ack} !== 3'b000) begin
        n_fail++;
        $display("FAIL idle i=%0d: {clk_out,tick,ack} got %b expected 000", i, {clk_out, tick, div_ack});
      end
    end
    en = 1'b1;
    check_periods(1000, 1, "reenable");
    en       = 1'b0;
    div_val  = 16'd3;
    div_load = 1'b1;
    cyc();
    div_load = 1'b0;
    n_tests++;
    if ({div_ack, div_pend, clk_out} !== 3'b100 || div_cur !== 16'd3) begin
      n_fail++;
      $display("FAIL idle_load: {ack,pend,clk_out}=%b div_cur=%0d expected 100 3",
               {div_ack, div_pend, clk_out}, div_cur);
    end
    en = 1'b1;
    check_periods(3, 2, "ratio3");
  endtask

  initial begin
    test_reset();
    test_default_run();
    test_reload_mid_period();
    test_ratio_five();
    test_clamp();
    test_back_to_back();
    test_async_reset_idle();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
